// File: rtl/vga_sched_pkg.sv
// ----------------------------------------------------------------------------
// vga_sched_pkg
// Shared types and constants for the frame-synchronous update scheduler.
//   sched_state_t : scheduler FSM state encoding
//   VIS_ROWS / VS_TOTAL_LINES / H_TOTAL_CYC : 640x480 timing geometry
//   ROW_W         : width of the visible-row index
//   idx_width()   : client-index width, never narrower than one bit
// ----------------------------------------------------------------------------
package vga_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    localparam int VIS_ROWS       = 480;
    localparam int VS_TOTAL_LINES = 521;
    localparam int H_TOTAL_CYC    = 1600;

    // Row counter only has to span the visible region.
    localparam int ROW_W = $clog2(VIS_ROWS);

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_frame_sched_if.sv
// ----------------------------------------------------------------------------
// vga_frame_sched_if
// Client handshake bundle between the scheduler and the game-logic clients.
//   start     : one-hot, one-cycle start pulse (scheduler -> client)
//   done      : per-client completion pulse     (client -> scheduler)
//   client_en : per-client enable mask, latched by the scheduler at launch
// Modports: master = scheduler side, slave = client side.
// ----------------------------------------------------------------------------
interface vga_frame_sched_if #(
    parameter int N_CLIENTS = 4
);
    logic [N_CLIENTS-1:0] start;
    logic [N_CLIENTS-1:0] done;
    logic [N_CLIENTS-1:0] client_en;

    modport master (
        output start,
        input  done,
        input  client_en
    );

    modport slave (
        input  start,
        output done,
        output client_en
    );
endinterface

// File: rtl/Counter.sv
// ----------------------------------------------------------------------------
// Counter
// Generic up-counter that wraps from MAX back to zero.
//   clk   : clock
//   srst  : synchronous active-high reset, clears the count
//   inc   : advance by one this cycle
//   count : current value
// ----------------------------------------------------------------------------
module Counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= (count_reg == MAX) ? '0 : count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/frame_edge_detect.sv
// ----------------------------------------------------------------------------
// frame_edge_detect
// Derives frame-level events from the VGA timing generator outputs.
//   clk        : clock
//   srst       : synchronous active-high reset
//   vs         : vertical sync, low during the sync pulse
//   blank      : high outside the visible region
//   row        : visible row index, meaningful while blank is low
//   frame_tick : one-cycle pulse, the cycle after VS is first seen low
//   disp_start : high in the cycle blank falls on row 0
// ----------------------------------------------------------------------------
module frame_edge_detect
    import vga_sched_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             vs,
    input  logic             blank,
    input  logic [ROW_W-1:0] row,
    output logic             frame_tick,
    output logic             disp_start
);

    logic vs_prev_reg;
    logic blank_prev_reg;
    logic frame_tick_reg;

    // vs_prev resets low so a VS that is already low when reset releases
    // is not mistaken for a falling edge. blank_prev resets high so the
    // first real blank fall is still seen.
    always_ff @(posedge clk) begin
        if (srst) begin
            vs_prev_reg    <= 1'b0;
            blank_prev_reg <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            vs_prev_reg    <= vs;
            blank_prev_reg <= blank;
            frame_tick_reg <= vs_prev_reg & ~vs;
        end
    end

    assign frame_tick = frame_tick_reg;

    // Kept combinational against the registered blank history so the
    // downstream overrun flag lands one cycle after the display begins.
    assign disp_start = blank_prev_reg & ~blank & (row == '0);

endmodule

// File: rtl/vga_frame_sched.sv
// ----------------------------------------------------------------------------
// vga_frame_sched
// Frame-synchronous update scheduler. On each VS falling edge (subject to the
// frame divider and en) it walks the update clients in index order, issuing a
// start pulse to each enabled client and waiting for its done pulse, so all
// game-state updates happen during vertical blanking.
//   CLOCK_50      : system clock
//   reset         : synchronous active-high reset
//   VS/blank/row  : timing generator outputs
//   en            : scheduler enable (game running)
//   cli           : client handshake (start / done / client_en)
//   active_client : index currently selected / served
//   busy          : FSM not idle
//   frame_tick    : one-cycle pulse per VS falling edge
//   frame_cnt     : number of frame ticks, wraps
//   overrun       : sticky, a sequence was still running at display start
//                   or at the next frame tick
//   clear_overrun : clears overrun (a simultaneous set wins)
// ----------------------------------------------------------------------------
module vga_frame_sched
    import vga_sched_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int FRAME_DIV = 1,
    parameter int FCNT_W    = 16,
    localparam int IDX_W    = idx_width(N_CLIENTS)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              VS,
    input  logic              blank,
    input  logic [ROW_W-1:0]  row,
    input  logic              en,
    vga_frame_sched_if.master cli,
    output logic [IDX_W-1:0]  active_client,
    output logic              busy,
    output logic              frame_tick,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              overrun,
    input  logic              clear_overrun
);

    // Divider never exceeds 254, so eight bits cover every legal FRAME_DIV.
    localparam int               DIV_W    = 8;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(FRAME_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

    sched_state_t         state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [N_CLIENTS-1:0] mask_reg, mask_next;
    logic [N_CLIENTS-1:0] start_vec;
    logic                 tick;
    logic                 disp_start;
    logic [DIV_W-1:0]     div_cnt;
    logic                 overrun_reg;

    // ------------------------------------------------------------------
    // Frame events and counters
    // ------------------------------------------------------------------
    frame_edge_detect u_edge (
        .clk        (CLOCK_50),
        .srst       (reset),
        .vs         (VS),
        .blank      (blank),
        .row        (row),
        .frame_tick (tick),
        .disp_start (disp_start)
    );

    Counter #(
        .WIDTH (FCNT_W),
        .MAX   ({FCNT_W{1'b1}})
    ) u_frame_cnt (
        .clk   (CLOCK_50),
        .srst  (reset),
        .inc   (tick),
        .count (frame_cnt)
    );

    // Divider advances on every tick, even ones that cannot launch.
    Counter #(
        .WIDTH (DIV_W),
        .MAX   (DIV_MAX)
    ) u_div_cnt (
        .clk   (CLOCK_50),
        .srst  (reset),
        .inc   (tick),
        .count (div_cnt)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            mask_reg  <= mask_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        mask_next  = mask_reg;
        case (state_reg)
            IDLE: begin
                if (tick && en && (div_cnt == '0)) begin
                    mask_next  = cli.client_en;
                    idx_next   = '0;
                    state_next = SEL;
                end
            end
            SEL: begin
                // One cycle per examined index; disabled clients are skipped.
                if (mask_reg[idx_reg]) begin
                    state_next = START;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                // Only the served client's done bit counts. Dropping en lets
                // the current client finish but stops the walk here.
                if (cli.done[idx_reg]) begin
                    if ((idx_reg == LAST_IDX) || !en) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = SEL;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot start decode, asserted for the single START cycle.
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_start
        assign start_vec[gi] = (state_reg == START) && (idx_reg == IDX_W'(gi));
    end

    // ------------------------------------------------------------------
    // Overrun: set wins over clear
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overrun_reg <= 1'b0;
        end else if ((disp_start || tick) && (state_reg != IDLE)) begin
            overrun_reg <= 1'b1;
        end else if (clear_overrun) begin
            overrun_reg <= 1'b0;
        end
    end

    assign cli.start     = start_vec;
    assign active_client = idx_reg;
    assign busy          = (state_reg != IDLE);
    assign frame_tick    = tick;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_vga_frame_sched.sv
module tb_vga_frame_sched;
    import vga_sched_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             VS;
    logic             blank;
    logic [ROW_W-1:0] row;
    logic             en;
    logic             clear_overrun;

    logic [1:0]  active_client, active_client_d;
    logic        busy, busy_d;
    logic        frame_tick, frame_tick_d;
    logic [15:0] frame_cnt, frame_cnt_d;
    logic        overrun, overrun_d;

    vga_frame_sched_if #(.N_CLIENTS(N)) cli ();
    vga_frame_sched_if #(.N_CLIENTS(N)) cli_d ();

    vga_frame_sched #(.N_CLIENTS(N), .FRAME_DIV(1), .FCNT_W(16)) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .VS            (VS),
        .blank         (blank),
        .row           (row),
        .en            (en),
        .cli           (cli),
        .active_client (active_client),
        .busy          (busy),
        .frame_tick    (frame_tick),
        .frame_cnt     (frame_cnt),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    // Second instance exercises the frame divider; its clients answer after one cycle.
    vga_frame_sched #(.N_CLIENTS(N), .FRAME_DIV(2), .FCNT_W(16)) u_div (
        .CLOCK_50      (clk),
        .reset         (reset),
        .VS            (VS),
        .blank         (blank),
        .row           (row),
        .en            (en),
        .cli           (cli_d),
        .active_client (active_client_d),
        .busy          (busy_d),
        .frame_tick    (frame_tick_d),
        .frame_cnt     (frame_cnt_d),
        .overrun       (overrun_d),
        .clear_overrun (clear_overrun)
    );

    assign cli_d.client_en = cli.client_en;
    always @(posedge clk) cli_d.done <= cli_d.start;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int client;
        int at;
    } exp_t;
    exp_t exp_q[$];

    int d_tab[N];
    int n_ticks = 0;
    int exp_div_launches = 0;
    int div_launches = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0d required %0d", name, cyc, act, req);
        end else begin
            $display("ok   %s: cycle %0d value %0d", name, cyc, act);
        end
    endtask

    task automatic go_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        go_cyc(c);
        @(negedge clk);
    endtask

    // Reference: walk clients in order; enabled client i starts one cycle after
    // its select cycle, its done comes d_tab[i] cycles later, the next select
    // follows done; a disabled client costs one select cycle. Returns the first idle cycle.
    function automatic int push_seq(input int T, input logic [3:0] mask, input int nserve);
        int t = T + 2;
        int served = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (served == nserve) break;
                exp_q.push_back('{client: i, at: t + 1});
                t = t + d_tab[i] + 2;
                served++;
            end else begin
                t = t + 1;
            end
        end
        return t;
    endfunction

    // Divider model: a launch is eligible on every second tick since reset.
    task automatic note_tick(input logic en_at_tick);
        if ((n_ticks % 2 == 0) && en_at_tick) exp_div_launches++;
        n_ticks++;
    endtask

    // Starts a frame in the current cycle T: VS falls now.
    task automatic frame(input logic [3:0] mask, input logic en_v, input int nserve,
                         output int T, output int t_end);
        T = cyc;
        cli.client_en = mask;
        en = en_v;
        VS = 1'b0;
        t_end = T;
        if (en_v) t_end = push_seq(T, mask, nserve);
        note_tick(en_v);
    endtask

    // Client responder: done exactly d_tab[i] cycles after start[i].
    initial begin
        logic [N-1:0] pend;
        int due[N];
        pend = '0;
        cli.done = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) pend = '0;
            for (int i = 0; i < N; i++) begin
                cli.done[i] = pend[i] && (cyc == due[i]);
                if (cli.done[i]) pend[i] = 1'b0;
                if (cli.start[i]) begin
                    pend[i] = 1'b1;
                    due[i]  = cyc + d_tab[i];
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every start pulse.
    initial begin
        logic busy_d_prev;
        exp_t e;
        busy_d_prev = 1'b0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL start_missing: client %0d required at cycle %0d, not seen by %0d", e.client, e.at, cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (cli.start[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL start_unexpected: client %0d at cycle %0d, required none", i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.client != i || e.at != cyc || active_client !== 2'(i)) begin
                            errors++;
                            $display("FAIL start_match: got client %0d at cycle %0d (active %0d), required client %0d at cycle %0d",
                                     i, cyc, active_client, e.client, e.at);
                        end else begin
                            $display("ok   start: client %0d at cycle %0d", i, cyc);
                        end
                    end
                end
            end
            if (busy_d && !busy_d_prev) div_launches++;
            busy_d_prev = busy_d;
        end
    end

    initial begin
        int T;
        int t_end;
        reset = 1'b1;
        VS = 1'b1;
        blank = 1'b1;
        row = '0;
        en = 1'b0;
        clear_overrun = 1'b0;
        cli.client_en = '0;
        for (int i = 0; i < N; i++) d_tab[i] = 5;

        // Reset state
        go_cyc(3);
        at_neg(3);
        chk("rst_busy", busy, 0);
        chk("rst_start", cli.start, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_active", active_client, 0);
        chk("rst_tick", frame_tick, 0);
        reset = 1'b0;
        en = 1'b1;
        go_cyc(10);

        // All clients, 5-cycle responses: starts T+3, T+10, T+17, T+24
        frame(4'hF, 1'b1, N, T, t_end);
        at_neg(T + 1);
        chk("a_tick", frame_tick, 1);
        chk("a_busy_pre", busy, 0);
        at_neg(T + 2);
        chk("a_tick_once", frame_tick, 0);
        chk("a_busy_first", busy, 1);
        go_cyc(T + 3);
        VS = 1'b1;
        at_neg(T + 29);
        chk("a_busy_last", busy, 1);
        at_neg(T + 30);
        chk("a_busy_end", busy, 0);
        chk("a_frame_cnt", frame_cnt, n_ticks);
        go_cyc(T + 40);

        // Sparse mask 0101: clients 1 and 3 skipped
        frame(4'b0101, 1'b1, N, T, t_end);
        go_cyc(T + 3);
        VS = 1'b1;
        go_cyc(T + 40);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            logic [3:0] m;
            logic e_v;
            m = 4'($urandom_range(0, 15));
            e_v = ($urandom_range(0, 5) != 0);
            for (int i = 0; i < N; i++) d_tab[i] = $urandom_range(1, 6);
            frame(m, e_v, N, T, t_end);
            go_cyc(T + 3);
            VS = 1'b1;
            go_cyc(T + 45);
            blank = 1'b0;
            row = '0;
            go_cyc(T + 48);
            blank = 1'b1;
            at_neg(T + 55);
            chk("rnd_overrun", overrun, 0);
            chk("rnd_frame_cnt", frame_cnt, n_ticks);
            en = 1'b1;
            go_cyc(T + 60);
        end

        // Overrun: client 1 holds done past display start and the next tick
        d_tab[0] = 5; d_tab[1] = 40; d_tab[2] = 5; d_tab[3] = 5;
        frame(4'hF, 1'b1, N, T, t_end);
        go_cyc(T + 3);
        VS = 1'b1;
        go_cyc(T + 15);
        blank = 1'b0;
        row = 9'd7;
        go_cyc(T + 17);
        blank = 1'b1;
        row = '0;
        at_neg(T + 18);
        chk("ovr_row_nonzero", overrun, 0);
        go_cyc(T + 20);
        blank = 1'b0;
        row = '0;
        clear_overrun = 1'b1;
        at_neg(T + 21);
        chk("ovr_set_wins", overrun, 1);
        clear_overrun = 1'b0;
        go_cyc(T + 22);
        clear_overrun = 1'b1;
        blank = 1'b1;
        at_neg(T + 23);
        chk("ovr_clear", overrun, 0);
        clear_overrun = 1'b0;
        go_cyc(T + 30);
        VS = 1'b0;
        note_tick(1'b1);
        at_neg(T + 31);
        chk("ovr_tick_busy", frame_tick, 1);
        at_neg(T + 32);
        chk("ovr_tick_set", overrun, 1);
        go_cyc(T + 33);
        VS = 1'b1;
        at_neg(T + 40);
        chk("ovr_frame_cnt", frame_cnt, n_ticks);
        at_neg(t_end - 1);
        chk("ovr_busy_tail", busy, 1);
        at_neg(t_end);
        chk("ovr_busy_end", busy, 0);
        go_cyc(T + 80);

        // en drops while client 0 is waiting: nothing further starts
        for (int i = 0; i < N; i++) d_tab[i] = 5;
        frame(4'hF, 1'b1, 1, T, t_end);
        go_cyc(T + 3);
        VS = 1'b1;
        go_cyc(T + 5);
        en = 1'b0;
        at_neg(T + 8);
        chk("en_busy_wait", busy, 1);
        at_neg(T + 9);
        chk("en_stop_idle", busy, 0);
        go_cyc(T + 20);
        en = 1'b1;
        go_cyc(T + 40);

        // Reset during WAIT with VS held low across reset
        d_tab[0] = 20;
        frame(4'hF, 1'b1, 1, T, t_end);
        go_cyc(T + 3);
        VS = 1'b1;
        go_cyc(T + 6);
        reset = 1'b1;
        VS = 1'b0;
        at_neg(T + 7);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", cli.start, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_active", active_client, 0);
        chk("mid_rst_tick", frame_tick, 0);
        reset = 1'b0;
        n_ticks = 0;
        go_cyc(T + 12);
        VS = 1'b1;
        at_neg(T + 16);
        chk("post_rst_no_tick", frame_cnt, 0);
        chk("post_rst_idle", busy, 0);
        go_cyc(T + 20);

        // Normal operation resumes after reset
        for (int i = 0; i < N; i++) d_tab[i] = $urandom_range(1, 6);
        frame(4'hF, 1'b1, N, T, t_end);
        go_cyc(T + 3);
        VS = 1'b1;
        go_cyc(T + 40);

        at_neg(cyc + 1);
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_frame_cnt", frame_cnt, n_ticks);
        chk("div_frame_cnt", frame_cnt_d, n_ticks);
        chk("div_launches", div_launches, exp_div_launches);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_sched.md
Name: vga_frame_sched

Overview:
Frame-synchronous update scheduler driven by the VGA timing generator outputs (VS, blank, row).
- On each vertical sync falling edge, sequences a fixed-order series of game-logic update clients (bird physics, pipe scroll, collision, score) through a start/done handshake, so all state updates land during vertical blanking.
- Counts frames, supports a frame divider, and flags overrun when an update sequence is still running when the display region begins.

Parameters:
N_CLIENTS, 4, number of update clients, served in index order 0..N_CLIENTS-1
FRAME_DIV, 1, launch a sequence every FRAME_DIV-th frame (1..255)
FCNT_W, 16, frame counter width

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
VS  in  1  vertical sync from timing generator; low during sync pulse
blank  in  1  high outside the visible region
row  in  9  current visible row, valid when blank=0
en  in  1  scheduler enable (game running)
client_en  in  N_CLIENTS  per-client enable mask, latched at sequence launch
done  in  N_CLIENTS  client i completion pulse, sampled only while waiting on client i
start  out  N_CLIENTS  one-hot, one-cycle start pulse to client i
active_client  out  $clog2(N_CLIENTS)  index currently selected/served
busy  out  1  high whenever FSM is not IDLE
frame_tick  out  1  one-cycle pulse per VS falling edge
frame_cnt  out  FCNT_W  frame_tick count, wraps modulo 2^FCNT_W
overrun  out  1  sticky error flag
clear_overrun  in  1  clears overrun

Behaviour:
- Reset (synchronous): state=IDLE; start=0; active_client=0; busy=0; frame_tick=0; frame_cnt=0; overrun=0; divider=0; vs_prev=0; blank_prev=1; mask=0.
  - vs_prev=0 prevents a false tick after reset.
- Edge detect (registered):
  - VS sampled 1 at cycle T-1 and 0 at cycle T -> frame_tick=1 in cycle T+1 only.
  - Display start is detected when blank falls and row==0.
- Divider:
  - Increments on every frame_tick; wraps at FRAME_DIV-1 back to 0.
  - A launch is eligible when the divider value is 0 at the tick.
  - frame_cnt increments on every tick, regardless of en or divider.
- FSM states: IDLE, SEL, START, WAIT.
  - IDLE: frame_tick & en & divider==0 -> latch mask=client_en, idx=0, go SEL. Otherwise stay in IDLE.
  - SEL (1 cycle per examined index):
    - mask[idx]=1 -> go START.
    - Else if idx==N_CLIENTS-1 -> go IDLE.
    - Else idx++ and stay in SEL.
  - START (1 cycle): start[idx]=1 -> go WAIT.
  - WAIT: done[idx]=1 ->
    - If idx==N_CLIENTS-1 or en==0 -> go IDLE.
    - Else idx++ and go SEL.
    - done on other bits, or asserted during START, is ignored.
- Latency from the first VS-low cycle T:
  - tick at T+1.
  - SEL at T+2.
  - start of the first enabled client (index 0) at T+3; each skipped client adds 1 cycle.
  - Client period = (start-to-done cycles) + 2.
- Stopping early: if en deasserts mid-sequence, the current client finishes and no further clients start. There is no abort.
- Overrun:
  - Set when display start is detected while busy=1.
  - Also set when frame_tick arrives while busy=1; that tick launches nothing, but frame_cnt and the divider still advance.
  - The running sequence continues in both cases.
  - clear_overrun clears the flag; a set in the same cycle wins.
- No timeout: a client that never returns done holds the FSM in WAIT until reset.
- Reset mid-operation: return to IDLE next cycle. No start pulses until the next valid VS falling edge.

Decomposition:
- Package vga_sched_pkg: state enum (IDLE, SEL, START, WAIT); constants VIS_ROWS=480, VS_TOTAL_LINES=521, H_TOTAL_CYC=1600.
- Sub-module frame_edge_detect: produces frame_tick and disp_start from VS, blank and row.
- frame_cnt and the divider use the existing Counter module.

Test Plan:
- All four clients enabled, each returns done 5 cycles after its start, VS falls at T -> starts at T+3, T+10, T+17, T+24; busy high T+2..T+29; frame_cnt=1.
- client_en=4'b0101 -> start[0] at T+3; after done at T+8, start[2] at T+11; start[1] and start[3] never pulse.
- Client 1 withholds done past blank falling with row=0 -> overrun=1 the following cycle. A later done resumes the sequence; client 2 still starts.
- FRAME_DIV=2, four VS edges -> sequences launch on ticks 1 and 3 only; frame_cnt=4.
- Reset asserted during WAIT -> all outputs at reset values next cycle. No start until the next VS falling edge; a VS already low at reset produces no tick.
- overrun set and clear_overrun asserted in the same cycle -> overrun=1. clear_overrun alone on a later cycle -> overrun=0.
